regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Initiator side of the 32x32 register-file cell array. Accepts one access request (optional write
//  plus two reads) over a valid/ready handshake and drives the array's one-hot write_sl, shared write
//  data and one-hot tri-state read selects. Samples the A/B read buses and returns them on a
//  valid/ready response channel. Sits between the datapath/decode stage and the register-file array.
// PARAMETERS
//  NREGS  32  number of register rows (one-hot select width)
//  WIDTH  32  data width per register
//  AW     5   address width; addresses >= NREGS are out of range
// PORTS
//  clk          input   1      rising-edge clock
//  rst          input   1      synchronous, active-high reset
//  req_valid    input   1      request present
//  req_ready    output  1      controller can accept a request
//  req_we       input   1      1 = perform write before the reads
//  req_waddr    input   AW     write row
//  req_wdata    input   WIDTH  write data
//  req_addr_a   input   AW     read row for port A
//  req_addr_b   input   AW     read row for port B
//  rf_write_sl  output  NREGS  one-hot write select to array rows
//  rf_wdata     output  WIDTH  write data to all rows (cell 'in')
//  rf_sel_a     output  NREGS  one-hot port-A tri-state enable
//  rf_sel_b     output  NREGS  one-hot port-B tri-state enable
//  rf_out_a     input   WIDTH  shared port-A bus from array
//  rf_out_b     input   WIDTH  shared port-B bus from array
//  rsp_valid    output  1      read data available
//  rsp_ready    input   1      consumer accepts response
//  rsp_data_a   output  WIDTH  sampled port-A data
//  rsp_data_b   output  WIDTH  sampled port-B data
// BEHAVIOUR
//  - All rf_*, rsp_* outputs and state are registers; rst at a clock edge forces state IDLE,
//    rf_write_sl=0, rf_sel_a=0, rf_sel_b=0, rf_wdata=0, rsp_valid=0, rsp_data_a/b=0, req_ready=1.
//  - FSM: IDLE -> (req_we ? WRITE : READ) -> READ -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid&req_ready latch all request fields; next state per above.
//  - WRITE (exactly 1 cycle): rf_write_sl one-hot at waddr, rf_wdata=wdata; row captures at the
//    edge ending this cycle. waddr >= NREGS -> rf_write_sl=0 (write silently dropped).
//  - READ (exactly 1 cycle): rf_sel_a/rf_sel_b one-hot at addr_a/addr_b; rf_write_sl=0. At the edge
//    ending READ, rsp_data_a/b <= rf_out_a/b; an out-of-range address gives sel=0 and data 0 (bus
//    floats, never sampled). addr_a==addr_b legal: both selects hit the same row.
//  - RESP: rsp_valid=1, data held stable until rsp_valid&rsp_ready; then IDLE, rsp_valid=0.
//  - Selects and write_sl are all-zero outside READ/WRITE; at most one bit set in each vector.
//  - req_ready=0 in WRITE, READ, RESP: one transaction in flight, no pipelining.
//  - Write-then-read: a read of waddr in the same request returns the new wdata.
//  - Latency from accept edge to rsp_valid: 2 cycles without write, 3 with write; back-to-back
//    throughput 1 request per 3 (4 with write) cycles when rsp_ready held high.
//  - Reset mid-transaction: aborts; a WRITE cycle coincident with rst edge does not drive write_sl
//    afterwards, a row already written stays written; rsp_valid drops, pending response is lost.
// TESTING
//  1 Reset: rst=1 two cycles -> all selects 0, rsp_valid=0, req_ready=1, rsp_data_a/b=0.
//  2 Write row 5 = 0xDEADBEEF, read A=5,B=0 -> rf_write_sl=0x00000020 for 1 cycle, then
//    rf_sel_a=0x20, rf_sel_b=0x1; rsp_valid 3 cycles after accept, rsp_data_a=0xDEADBEEF.
//  3 Read-only A=7,B=7 after row 7=0x12345678 -> both sel=0x80, rsp after 2 cycles, both data equal.
//  4 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0, new
//    req_valid ignored; accepted only after response handshake.
//  5 Out of range (NREGS=24, addr 30): write_sl/sel stay 0, rsp_data=0, no row modified.
//  6 rst asserted during RESP -> next cycle rsp_valid=0, req_ready=1, stored rows unchanged.

Source files
------------

// File: rtl/regfile_port_ctrl_if.sv
// Request, register-array and response signals between decode, regfile_port_ctrl and the cell array.
// master = decode/array side, slave = controller side.
interface regfile_port_ctrl_if #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_waddr;
    logic [WIDTH-1:0] req_wdata;
    logic [AW-1:0]    req_addr_a;
    logic [AW-1:0]    req_addr_b;

    logic [NREGS-1:0] rf_write_sl;
    logic [WIDTH-1:0] rf_wdata;
    logic [NREGS-1:0] rf_sel_a;
    logic [NREGS-1:0] rf_sel_b;
    logic [WIDTH-1:0] rf_out_a;
    logic [WIDTH-1:0] rf_out_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data_a;
    logic [WIDTH-1:0] rsp_data_b;

    modport master (
        output req_valid, req_we, req_waddr, req_wdata, req_addr_a, req_addr_b,
        output rf_out_a, rf_out_b, rsp_ready,
        input  req_ready, rf_write_sl, rf_wdata, rf_sel_a, rf_sel_b,
        input  rsp_valid, rsp_data_a, rsp_data_b
    );

    modport slave (
        input  req_valid, req_we, req_waddr, req_wdata, req_addr_a, req_addr_b,
        input  rf_out_a, rf_out_b, rsp_ready,
        output req_ready, rf_write_sl, rf_wdata, rf_sel_a, rf_sel_b,
        output rsp_valid, rsp_data_a, rsp_data_b
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: one request (optional write, two reads) -> one response.
// rsp_valid 2 cycles after accept (3 with write); req_ready low until the response handshakes.
module regfile_port_ctrl #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    regfile_port_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RESP} state_t;

    state_t           r_state,    w_state_nxt;
    logic [AW-1:0]    r_addr_a,   w_addr_a_nxt;
    logic [AW-1:0]    r_addr_b,   w_addr_b_nxt;
    logic [NREGS-1:0] r_write_sl, w_write_sl_nxt;
    logic [WIDTH-1:0] r_wdata,    w_wdata_nxt;
    logic [NREGS-1:0] r_sel_a,    w_sel_a_nxt;
    logic [NREGS-1:0] r_sel_b,    w_sel_b_nxt;
    logic             r_rsp_vld,  w_rsp_vld_nxt;
    logic [WIDTH-1:0] r_rsp_a,    w_rsp_a_nxt;
    logic [WIDTH-1:0] r_rsp_b,    w_rsp_b_nxt;
    logic             r_req_rdy,  w_req_rdy_nxt;

    function automatic logic f_in_range(input logic [AW-1:0] a);
        return (32'(a) < NREGS);
    endfunction

    // Out-of-range rows decode to an all-zero select so the access is dropped.
    function automatic logic [NREGS-1:0] f_onehot(input logic [AW-1:0] a);
        logic [NREGS-1:0] v;
        v = '0;
        if (f_in_range(a)) v[a] = 1'b1;
        return v;
    endfunction

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_a_nxt   = r_addr_a;
        w_addr_b_nxt   = r_addr_b;
        w_write_sl_nxt = '0;
        w_wdata_nxt    = '0;
        w_sel_a_nxt    = '0;
        w_sel_b_nxt    = '0;
        w_rsp_vld_nxt  = r_rsp_vld;
        w_rsp_a_nxt    = r_rsp_a;
        w_rsp_b_nxt    = r_rsp_b;
        w_req_rdy_nxt  = r_req_rdy;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && r_req_rdy) begin
                    w_addr_a_nxt  = bus.req_addr_a;
                    w_addr_b_nxt  = bus.req_addr_b;
                    w_req_rdy_nxt = 1'b0;
                    if (bus.req_we) begin
                        w_state_nxt    = ST_WRITE;
                        w_write_sl_nxt = f_onehot(bus.req_waddr);
                        w_wdata_nxt    = bus.req_wdata;
                    end else begin
                        w_state_nxt = ST_READ;
                        w_sel_a_nxt = f_onehot(bus.req_addr_a);
                        w_sel_b_nxt = f_onehot(bus.req_addr_b);
                    end
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_READ;
                w_sel_a_nxt = f_onehot(r_addr_a);
                w_sel_b_nxt = f_onehot(r_addr_b);
            end
            ST_READ: begin
                // A floating bus (no row selected) is never sampled.
                w_state_nxt   = ST_RESP;
                w_rsp_vld_nxt = 1'b1;
                w_rsp_a_nxt   = f_in_range(r_addr_a) ? bus.rf_out_a : '0;
                w_rsp_b_nxt   = f_in_range(r_addr_b) ? bus.rf_out_b : '0;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt   = ST_IDLE;
                    w_rsp_vld_nxt = 1'b0;
                    w_req_rdy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_rsp_vld_nxt = 1'b0;
                w_req_rdy_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_write_sl <= '0;
            r_wdata    <= '0;
            r_sel_a    <= '0;
            r_sel_b    <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_a    <= '0;
            r_rsp_b    <= '0;
            r_req_rdy  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_addr_a   <= w_addr_a_nxt;
            r_addr_b   <= w_addr_b_nxt;
            r_write_sl <= w_write_sl_nxt;
            r_wdata    <= w_wdata_nxt;
            r_sel_a    <= w_sel_a_nxt;
            r_sel_b    <= w_sel_b_nxt;
            r_rsp_vld  <= w_rsp_vld_nxt;
            r_rsp_a    <= w_rsp_a_nxt;
            r_rsp_b    <= w_rsp_b_nxt;
            r_req_rdy  <= w_req_rdy_nxt;
        end
    end

    assign bus.req_ready   = r_req_rdy;
    assign bus.rf_write_sl = r_write_sl;
    assign bus.rf_wdata    = r_wdata;
    assign bus.rf_sel_a    = r_sel_a;
    assign bus.rf_sel_b    = r_sel_b;
    assign bus.rsp_valid   = r_rsp_vld;
    assign bus.rsp_data_a  = r_rsp_a;
    assign bus.rsp_data_b  = r_rsp_b;
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: cell-array model on the rf_* bus, reference register contents
// kept as a plain array, randomized traffic plus directed reset/backpressure/out-of-range cases.
module tb_regfile_port_ctrl;
    localparam int NR = 24;
    localparam int W  = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_port_ctrl_if #(.NREGS(NR), .WIDTH(W), .AW(AW)) bus();

    regfile_port_ctrl #(.NREGS(NR), .WIDTH(W), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Cell array: rows capture on write_sl, unselected buses carry junk.
    logic [W-1:0] mem [NR];
    logic [W-1:0] junk_a, junk_b;
    always_ff @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            if (bus.rf_write_sl[i]) mem[i] <= bus.rf_wdata;
        junk_a <= $urandom;
        junk_b <= $urandom;
    end
    always_comb begin
        bus.rf_out_a = junk_a;
        bus.rf_out_b = junk_b;
        for (int i = 0; i < NR; i++) begin
            if (bus.rf_sel_a[i]) bus.rf_out_a = mem[i];
            if (bus.rf_sel_b[i]) bus.rf_out_b = mem[i];
        end
    end

    logic [W-1:0] ref_mem [NR];
    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] exp_oh(input logic [AW-1:0] a);
        logic [NR-1:0] v;
        v = '0;
        if (int'(a) < NR) v[int'(a)] = 1'b1;
        return v;
    endfunction

    task automatic garbage();
        bus.req_valid  = 1'($urandom % 2);
        bus.req_we     = 1'($urandom % 2);
        bus.req_waddr  = AW'($urandom);
        bus.req_wdata  = $urandom;
        bus.req_addr_a = AW'($urandom);
        bus.req_addr_b = AW'($urandom);
    endtask

    task automatic present(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                           input logic [AW-1:0] aa, input logic [AW-1:0] ab);
        chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_waddr  = wa;
        bus.req_wdata  = wd;
        bus.req_addr_a = aa;
        bus.req_addr_b = ab;
    endtask

    task automatic txn(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ab, input int stall);
        logic [W-1:0] ea, eb;
        if (we && int'(wa) < NR) ref_mem[int'(wa)] = wd;
        ea = (int'(aa) < NR) ? ref_mem[int'(aa)] : '0;
        eb = (int'(ab) < NR) ? ref_mem[int'(ab)] : '0;
        present(we, wa, wd, aa, ab);
        @(negedge clk);
        garbage();
        if (we) begin
            chk("write_sl", 64'(bus.rf_write_sl), 64'(exp_oh(wa)));
            if (int'(wa) < NR) chk("rf_wdata", 64'(bus.rf_wdata), 64'(wd));
            chk("sel_a_in_write", 64'(bus.rf_sel_a), 64'd0);
            chk("rsp_valid_in_write", {63'd0, bus.rsp_valid}, 64'd0);
            chk("req_ready_in_write", {63'd0, bus.req_ready}, 64'd0);
            @(negedge clk);
            garbage();
        end
        chk("sel_a", 64'(bus.rf_sel_a), 64'(exp_oh(aa)));
        chk("sel_b", 64'(bus.rf_sel_b), 64'(exp_oh(ab)));
        chk("write_sl_in_read", 64'(bus.rf_write_sl), 64'd0);
        chk("rsp_valid_in_read", {63'd0, bus.rsp_valid}, 64'd0);
        chk("req_ready_in_read", {63'd0, bus.req_ready}, 64'd0);
        bus.rsp_ready = 1'($urandom % 2);
        @(negedge clk);
        for (int s = 0; s <= stall; s++) begin
            chk("rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("rsp_data_a", 64'(bus.rsp_data_a), 64'(ea));
            chk("rsp_data_b", 64'(bus.rsp_data_b), 64'(eb));
            chk("req_ready_in_resp", {63'd0, bus.req_ready}, 64'd0);
            chk("sel_in_resp", 64'(bus.rf_sel_a | bus.rf_sel_b | bus.rf_write_sl), 64'd0);
            garbage();
            bus.rsp_ready = (s == stall);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", {63'd0, bus.rsp_valid}, 64'd0);
        chk("req_ready_after_hs", {63'd0, bus.req_ready}, 64'd1);
    endtask

    task automatic check_rows(input string tag);
        for (int i = 0; i < NR; i++) chk(tag, 64'(mem[i]), 64'(ref_mem[i]));
    endtask

    initial begin
        logic [W-1:0] v;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_waddr = '0; bus.req_wdata = '0;
        bus.req_addr_a = '0; bus.req_addr_b = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_write_sl", 64'(bus.rf_write_sl), 64'd0);
        chk("rst_sel", 64'(bus.rf_sel_a | bus.rf_sel_b), 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_rsp_data", {bus.rsp_data_a, bus.rsp_data_b}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fill every row, reading it straight back (write-then-read).
        for (int i = 0; i < NR; i++) begin
            v = $urandom;
            txn(1'b1, AW'(i), v, AW'(i), AW'($urandom % NR), 0);
        end

        txn(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 0);
        txn(1'b1, 5'd7, 32'h12345678, 5'd1, 5'd2, 0);
        txn(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 0);
        txn(1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 5);
        txn(1'b1, 5'd30, 32'hCAFEF00D, 5'd30, 5'd30, 1);
        check_rows("rows_after_oor");
        txn(1'b1, 5'd23, 32'hA5A5A5A5, 5'd23, 5'd24, 2);

        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] ra, rb;
            ra = ($urandom % 8 == 0) ? AW'($urandom) : AW'($urandom % NR);
            rb = ($urandom % 8 == 0) ? AW'($urandom) : AW'($urandom % NR);
            txn(1'($urandom % 2), AW'($urandom), $urandom, ra, rb, int'($urandom % 4));
        end

        // Reset coincident with the WRITE cycle edge: the row still captures.
        present(1'b1, 5'd9, 32'h0BADCAFE, 5'd9, 5'd9);
        ref_mem[9] = 32'h0BADCAFE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_write_sl", 64'(bus.rf_write_sl), 64'd0);
        chk("rstw_sel", 64'(bus.rf_sel_a | bus.rf_sel_b), 64'd0);
        chk("rstw_req_ready", {63'd0, bus.req_ready}, 64'd1);
        txn(1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 0);

        // Reset while the response is stalled.
        present(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstr_rsp_valid_pre", {63'd0, bus.rsp_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstr_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rstr_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rstr_rsp_data", {bus.rsp_data_a, bus.rsp_data_b}, 64'd0);
        check_rows("rows_after_rst");
        txn(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
